// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter and its burst address generator.
// The state enum, requester IDs and the loader length clamp live here.
package dmem_arbiter_pkg;

  localparam int ADDR_W_DEF    = 7;
  localparam int DATA_W_DEF    = 32;
  localparam int BURST_MAX_DEF = 8;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_LDR  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    CORE_ISS,
    CORE_RSP,
    LDR_RUN,
    LDR_TAIL
  } state_t;

  // Zero-length bursts still move one word; oversize bursts are cut to the maximum.
  function automatic logic [3:0] clamp_len(input logic [3:0] len, input int burst_max);
    if (len == 4'd0) return 4'd1;
    if (int'(len) > burst_max) return 4'(burst_max);
    return len;
  endfunction

endpackage

// File: rtl/dmem_arbiter_addr_gen.sv
// Burst address generator: word address register with modulo wrap, clamped beat counter
// and last / next-to-last beat flags. Also reused as the single-beat core address register.
module burst_addr_gen
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [3:0]        len,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              next_last
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr <= '0;
      cnt  <= '0;
    end else if (load) begin
      addr <= start_addr;
      cnt  <= clamp_len(len, BURST_MAX);
    end else if (step) begin
      // Natural overflow of the ADDR_W-bit register gives the 127 -> 0 wrap.
      addr <= addr + ADDR_W'(1);
      cnt  <= cnt - 4'd1;
    end
  end

  assign last      = (cnt == 4'd1);
  assign next_last = (cnt == 4'd2);

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing one data-memory port between core load/store
// and a multi-beat burst loader; grants are locked until the access or burst completes.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [31:0]       core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_ack,
  output logic              core_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [3:0]        ldr_len,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_valid,
  output logic              ldr_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state, state_n;
  logic              last_grant, last_grant_n;
  logic              op_we, op_we_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic              ack_n, valid_n, done_n;
  logic              core_win;

  logic              ag_load, ag_step;
  logic [ADDR_W-1:0] ag_start, ag_addr;
  logic [3:0]        ag_len;
  logic              ag_last, ag_next_last;

  logic              unused_addr_bits;
  assign unused_addr_bits = ^{core_addr[31:ADDR_W+2], core_addr[1:0]};

  // Core wins a tie only when the loader had the previous grant.
  assign core_win = core_req & (~ldr_req | (last_grant == REQ_LDR));

  burst_addr_gen #(
    .ADDR_W    (ADDR_W),
    .BURST_MAX (BURST_MAX)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (ag_load),
    .step       (ag_step),
    .start_addr (ag_start),
    .len        (ag_len),
    .addr       (ag_addr),
    .last       (ag_last),
    .next_last  (ag_next_last)
  );

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    op_we_n      = op_we;
    wdata_n      = wdata_q;
    ack_n        = 1'b0;
    valid_n      = 1'b0;
    done_n       = 1'b0;
    ag_load      = 1'b0;
    ag_step      = 1'b0;
    ag_start     = core_addr[ADDR_W+1:2];
    ag_len       = 4'd1;

    case (state)
      IDLE: begin
        if (core_win) begin
          state_n      = CORE_ISS;
          last_grant_n = REQ_CORE;
          op_we_n      = core_we;
          wdata_n      = core_wdata;
          ag_load      = 1'b1;
        end else if (ldr_req) begin
          state_n      = LDR_RUN;
          last_grant_n = REQ_LDR;
          op_we_n      = ldr_we;
          ag_load      = 1'b1;
          ag_start     = ldr_addr;
          ag_len       = ldr_len;
          // A write beat is consumed in its issue cycle, so the first strobe lines up with beat 0.
          valid_n      = ldr_we;
          done_n       = ldr_we & (clamp_len(ldr_len, BURST_MAX) == 4'd1);
        end
      end
      CORE_ISS: begin
        state_n = CORE_RSP;
        ack_n   = 1'b1;
      end
      CORE_RSP: state_n = IDLE;
      LDR_RUN: begin
        ag_step = 1'b1;
        valid_n = ~op_we | ~ag_last;
        done_n  = op_we ? ag_next_last : ag_last;
        if (ag_last) state_n = op_we ? IDLE : LDR_TAIL;
      end
      LDR_TAIL: state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= REQ_LDR;
      op_we      <= 1'b0;
      wdata_q    <= '0;
      core_ack   <= 1'b0;
      ldr_valid  <= 1'b0;
      ldr_done   <= 1'b0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      op_we      <= op_we_n;
      wdata_q    <= wdata_n;
      core_ack   <= ack_n;
      ldr_valid  <= valid_n;
      ldr_done   <= done_n;
    end
  end

  assign core_stall = core_req & ~core_ack;
  // Memory read data is already registered; it is only steered to whichever requester owns the response.
  assign core_rdata = (core_ack & ~op_we) ? mem_rdata : '0;
  assign ldr_rdata  = (ldr_valid & ~op_we) ? mem_rdata : '0;

  assign mem_en    = (state == CORE_ISS) | (state == LDR_RUN);
  assign mem_we    = mem_en & op_we;
  assign mem_addr  = ag_addr;
  assign mem_wdata = ((state == CORE_ISS) && op_we) ? wdata_q :
                     ((state == LDR_RUN) && op_we)  ? ldr_wdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed table, multi-cycle corner sequences and
// randomized traffic against a transaction-level memory model.
module tb_dmem_arbiter;

  localparam int BMAX     = 8;
  localparam int SIG_ACK  = 0;
  localparam int SIG_DONE = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_ack, core_stall;
  logic        ldr_req, ldr_we;
  logic [6:0]  ldr_addr;
  logic [3:0]  ldr_len;
  logic [31:0] ldr_wdata, ldr_rdata;
  logic        ldr_valid, ldr_done;
  logic        mem_en, mem_we;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic        preload;
  logic [31:0] mem     [128];
  logic [31:0] ref_mem [128];
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } cvec_t;
  cvec_t tbl [7];

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_ack   (core_ack),
    .core_stall (core_stall),
    .ldr_req    (ldr_req),
    .ldr_we     (ldr_we),
    .ldr_addr   (ldr_addr),
    .ldr_len    (ldr_len),
    .ldr_wdata  (ldr_wdata),
    .ldr_rdata  (ldr_rdata),
    .ldr_valid  (ldr_valid),
    .ldr_done   (ldr_done),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Single-port memory with registered read data.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'(i);
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Called at the start of a cycle; returns the number of cycles until the signal is seen.
  task automatic wait_sig(input int sel, input int max, output int n);
    n = 0;
    smp();
    while ((((sel == SIG_ACK) ? core_ack : ldr_done) !== 1'b1) && (n < max)) begin
      tick();
      smp();
      n++;
    end
  endtask

  task automatic do_reset(input logic pm);
    rst = 1'b0; preload = pm;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_len = '0; ldr_wdata = '0;
    repeat (2) tick();
    preload = 1'b0;
    smp();
    chk1("rst mem_en", mem_en, 1'b0);
    chk1("rst core_ack", core_ack, 1'b0);
    chk1("rst core_stall", core_stall, 1'b0);
    chk1("rst ldr_valid", ldr_valid, 1'b0);
    chk1("rst ldr_done", ldr_done, 1'b0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk("rst core_rdata", core_rdata, 32'd0);
    tick();
    rst = 1'b1;
  endtask

  task automatic core_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp, input string tag);
    logic [6:0] w;
    w = addr[8:2];
    core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata;
    smp();
    chk1({tag, " c0 stall"}, core_stall, 1'b1);
    chk1({tag, " c0 mem_en"}, mem_en, 1'b0);
    tick(); smp();
    chk1({tag, " c1 stall"}, core_stall, 1'b1);
    chk1({tag, " c1 mem_en"}, mem_en, 1'b1);
    chk1({tag, " c1 mem_we"}, mem_we, we);
    chk({tag, " c1 mem_addr"}, 32'(mem_addr), 32'(w));
    if (we) chk({tag, " c1 mem_wdata"}, mem_wdata, wdata);
    chk1({tag, " c1 ack"}, core_ack, 1'b0);
    tick(); smp();
    chk1({tag, " c2 ack"}, core_ack, 1'b1);
    chk1({tag, " c2 stall"}, core_stall, 1'b0);
    chk1({tag, " c2 mem_en"}, mem_en, 1'b0);
    if (!we) chk({tag, " c2 rdata"}, core_rdata, exp);
    core_req = 1'b0;
    tick();
    if (we) ref_mem[w] = wdata;
  endtask

  task automatic ldr_burst(input logic we, input int addr, input int len, input logic [31:0] wbase,
                           input string tag);
    int n, last;
    logic ev, vv;
    n    = (len == 0) ? 1 : ((len > BMAX) ? BMAX : len);
    last = we ? n : n + 1;
    ldr_req = 1'b1; ldr_we = we; ldr_addr = 7'(addr); ldr_len = 4'(len);
    for (int j = 0; j <= last; j++) begin
      if (we && j >= 1 && j <= n) ldr_wdata = wbase + 32'(j - 1);
      smp();
      ev = (j >= 1) && (j <= n);
      vv = we ? ev : ((j >= 2) && (j <= n + 1));
      chk1($sformatf("%s c%0d mem_en", tag, j), mem_en, ev);
      if (ev) begin
        chk($sformatf("%s c%0d mem_addr", tag, j), 32'(mem_addr), 32'((addr + j - 1) % 128));
        chk1($sformatf("%s c%0d mem_we", tag, j), mem_we, we);
        if (we) chk($sformatf("%s c%0d mem_wdata", tag, j), mem_wdata, wbase + 32'(j - 1));
      end
      chk1($sformatf("%s c%0d valid", tag, j), ldr_valid, vv);
      chk1($sformatf("%s c%0d done", tag, j), ldr_done, (j == last));
      if (!we && vv)
        chk($sformatf("%s c%0d rdata", tag, j), ldr_rdata, ref_mem[(addr + j - 2) % 128]);
      if (j == last) ldr_req = 1'b0;
      tick();
    end
    if (we) for (int k = 0; k < n; k++) ref_mem[(addr + k) % 128] = wbase + 32'(k);
  endtask

  initial begin
    int n, dc, acks, mism, word;
    logic [31:0] a;
    for (int i = 0; i < 128; i++) ref_mem[i] = 32'(i);

    tbl[0] = '{1'b0, 32'h0000_0014, 32'h0,         32'd5};
    tbl[1] = '{1'b1, 32'h0000_0020, 32'hDEADBEEF, 32'h0};
    tbl[2] = '{1'b0, 32'h0000_0020, 32'h0,         32'hDEADBEEF};
    tbl[3] = '{1'b0, 32'h0000_01FC, 32'h0,         32'd127};
    tbl[4] = '{1'b1, 32'h0000_0200, 32'h12345678, 32'h0};
    tbl[5] = '{1'b0, 32'h0000_0000, 32'h0,         32'h12345678};
    tbl[6] = '{1'b0, 32'hFFFF_FE04, 32'h0,         32'd1};

    do_reset(1'b1);
    for (int i = 0; i < 7; i++)
      core_access(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp, $sformatf("vec%0d", i));

    ldr_burst(1'b0, 125, 4, 32'h0, "rd125");

    // Tie straight after reset: core first, then loader; next tie goes to core again.
    do_reset(1'b0);
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h8;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 7'd10; ldr_len = 4'd2;
    wait_sig(SIG_ACK, 10, n);
    chk("tie1 ack cycle", 32'(n), 32'd2);
    chk("tie1 core_rdata", core_rdata, ref_mem[2]);
    chk1("tie1 ldr idle", ldr_valid, 1'b0);
    core_req = 1'b0;
    tick();
    wait_sig(SIG_DONE, 20, n);
    chk("tie1 done cycle", 32'(n), 32'd3);
    chk("tie1 ldr_rdata", ldr_rdata, ref_mem[11]);
    ldr_req = 1'b0;
    tick();
    core_req = 1'b1; core_addr = 32'hC;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 7'd0; ldr_len = 4'd1;
    smp();
    chk1("tie2 c0 mem_en", mem_en, 1'b0);
    tick(); smp();
    chk1("tie2 c1 mem_en", mem_en, 1'b1);
    chk("tie2 c1 core first", 32'(mem_addr), 32'd3);
    tick();
    wait_sig(SIG_ACK, 10, n);
    chk("tie2 ack cycle", 32'(n), 32'd0);
    chk("tie2 core_rdata", core_rdata, ref_mem[3]);
    core_req = 1'b0;
    tick();
    wait_sig(SIG_DONE, 20, n);
    chk("tie2 done cycle", 32'(n), 32'd2);
    chk("tie2 ldr_rdata", ldr_rdata, ref_mem[0]);
    ldr_req = 1'b0;
    tick();

    // Core request arriving mid-burst must wait for the whole 8-beat write.
    dc = -1; acks = 0;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 7'd100; ldr_len = 4'd8;
    for (int j = 0; j < 20; j++) begin
      if (j >= 1) ldr_wdata = 32'hA000_0000 + 32'(j - 1);
      if (j == 3) begin core_req = 1'b1; core_we = 1'b0; core_addr = 32'd200; end
      smp();
      if (core_ack) acks++;
      if (ldr_done) begin dc = j; break; end
      tick();
    end
    chk("preempt done cycle", 32'(dc), 32'd8);
    chk("preempt no early ack", 32'(acks), 32'd0);
    for (int k = 0; k < 8; k++) ref_mem[100 + k] = 32'hA000_0000 + 32'(k);
    ldr_req = 1'b0;
    tick();
    wait_sig(SIG_ACK, 10, n);
    chk("preempt ack after done", 32'(n), 32'd2);
    chk("preempt core_rdata", core_rdata, ref_mem[50]);
    core_req = 1'b0;
    tick();

    ldr_burst(1'b1, 126, 0, 32'hB000_0000, "len0");
    ldr_burst(1'b1, 120, 15, 32'hC000_0000, "len15");
    ldr_burst(1'b0, 118, 12, 32'h0, "rdlen12");

    // Reset during the third beat of a read burst.
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 7'd40; ldr_len = 4'd6;
    tick(); tick(); tick();
    smp();
    chk1("abort c3 mem_en", mem_en, 1'b1);
    chk("abort c3 mem_addr", 32'(mem_addr), 32'd42);
    rst = 1'b0; ldr_req = 1'b0;
    tick(); smp();
    chk1("abort mem_en", mem_en, 1'b0);
    chk1("abort mem_we", mem_we, 1'b0);
    chk("abort mem_addr", 32'(mem_addr), 32'd0);
    chk("abort mem_wdata", mem_wdata, 32'd0);
    chk1("abort ldr_valid", ldr_valid, 1'b0);
    chk1("abort ldr_done", ldr_done, 1'b0);
    chk("abort ldr_rdata", ldr_rdata, 32'd0);
    chk1("abort core_ack", core_ack, 1'b0);
    chk("abort core_rdata", core_rdata, 32'd0);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(); smp();
      chk1($sformatf("abort+%0d done", k), ldr_done, 1'b0);
      chk1($sformatf("abort+%0d mem_en", k), mem_en, 1'b0);
    end
    tick();
    core_access(1'b0, 32'd168, 32'h0, ref_mem[42], "post-abort");

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        word = $urandom_range(0, 127);
        a = ($urandom & 32'hFFFF_FE00) | (32'(word) << 2);
        core_access(1'($urandom), a, $urandom, ref_mem[word], $sformatf("rnd%0d core", i));
      end else begin
        ldr_burst(1'($urandom), $urandom_range(0, 127), $urandom_range(0, 15), $urandom,
                  $sformatf("rnd%0d ldr", i));
      end
    end

    mism = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) mism++;
    chk("memory image mismatched words", 32'(mism), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
